uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
Serial-to-parallel receive path of the UART. It oversamples the serial input on the 16x baud `enable` tick and frames characters according to LCR (5-8 data bits, optional parity). It flags parity, framing and break conditions, then emits one 11-bit word per character as a single-cycle push strobe toward the receive FIFO. It sits beside the transmitter and shares its LCR, `enable` and reset sources. Loopback selects the transmitter output as the serial source.

Parameters:
- SYNC_STAGES, 2, number of flops in the serial-input synchronizer (must be ≥2).
- RX_WORD_W, 11, width of the pushed word (8 data + 3 status); fixed by uart_defines.

Ports:
- clk  input  1  system clock
- wb_rst_i  input  1  asynchronous active-high reset
- lcr  input  8  line control: [1:0] char length, [2] stop bits (ignored by the receiver), [3] PE, [4] EP, [5] SP, [6] BC (ignored)
- enable  input  1  16x baud tick, one clk wide
- srx_pad_i  input  1  serial line from pad, idle high, asynchronous
- stx_lb_i  input  1  transmitter serial output, used in loopback
- loopback  input  1  1 = take stx_lb_i instead of srx_pad_i
- rx_reset  input  1  synchronous abort: returns FSM to idle, drops any partial character
- rf_push  output  1  one-clk strobe: rf_data valid
- rf_data  output  11  {data[7:0], bi, pe, fe}; data in bits [10:3]
- rstate  output  3  current FSM state, for debug/LSR logic
- rx_busy  output  1  high in any state other than idle

Behaviour:
- Reset values: rf_push=0, rf_data=0, rstate=idle(0), rx_busy=0, synchronizer flops=1, counter=0, bit_count=0.
- Input path: the mux output (srx_pad_i or stx_lb_i) goes through SYNC_STAGES flops reset to 1. All sampling uses the synchronized bit `rx`. Latency from pad to `rx` is SYNC_STAGES clocks.
- The FSM and counters advance only on clk edges where enable=1. rx_reset (any clk) takes priority and forces idle, clears the counters and rf_push.
- The 4-bit tick counter counts down by 1 per enable.
- State s_idle(0): on an enable with rx=0, load counter=7 and go to s_start.
- State s_start(1): when counter==0, sample rx.
  - rx=1: treat as a glitch and return to s_idle.
  - rx=0: load counter=15, set bit_count = 4 + lcr[1:0] (data bits minus 1), clear the shift register, go to s_data.
- State s_data(2): when counter==0, shift rx in LSB-first and reload counter=15.
  - If bit_count==0: go to s_parity if lcr[3]=1, else s_stop.
  - Otherwise: decrement bit_count.
  - Data is right-justified; unused high bits are 0.
- State s_parity(3): when counter==0, sample the parity bit and reload counter=15, then go to s_stop. Expected parity by {EP,SP}:
  - 00: ~^data (odd)
  - 10: ^data (even)
  - 01: 1
  - 11: 0
  - pe = received bit != expected.
- State s_stop(4): when counter==0, sample the stop bit.
  - fe = ~rx.
  - bi = 1 when all data bits, the parity bit (if enabled) and the stop bit are 0.
  - Register rf_data and pulse rf_push for exactly the next clk cycle (independent of enable).
  - Next state is s_wait_high if rx=0, else s_idle.
- State s_wait_high(5): stay until an enable with rx=1, then go to s_idle. A held break therefore yields exactly one pushed word.
- Only one stop bit is ever checked, regardless of lcr[2].
- Changing lcr mid-character has undefined framing for that character only. The FSM must still return to idle within one character time.
- A line going low during s_stop counter countdown does not matter; only the sample at counter==0 counts.
- Unused state encodings 6 and 7 return to s_idle on the next enable.

Decomposition:
- uart_defines owns: state encodings, LCR bit indices (UART_LC_PE/EP/SP), RX_WORD_W, and the status bit positions in rf_data (BI=2, PE=1, FE=0).
- One sub-module: uart_sync_bit (SYNC_STAGES-deep synchronizer, reset value parameterised to 1), reusable by the modem-status inputs.

Test Plan:
- 8N1 (lcr=8'h03), send 0xA5 with 16 enables/bit: one rf_push, rf_data=11'b10100101_000, then rx_busy=0.
- 7E1 (lcr=8'h1A), send 0x35 with the correct parity bit 0: pe=0. Resend with parity bit 1: rf_data=11'b00110101_010.
- 5N1 (lcr=8'h00), send 0x1F with the stop bit forced 0: fe=1, bi=0, FSM enters s_wait_high and returns to idle only after the line goes high.
- Hold the line low for 3 character times at 8N1: exactly one push, rf_data=11'b00000000_101 (bi=1, fe=1); no further pushes until the line goes high then low again.
- Start glitch of 4 enable ticks low: no push, FSM back to idle. rx_reset asserted mid s_data: no push, rstate=0 next clk, and a following 0x5A is received correctly.
- loopback=1 with srx_pad_i=0 stuck and 0xC3 driven on stx_lb_i: rf_data data field=0xC3, status bits 0.

Source files
------------

// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receive path: state encodings, LCR bit indices,
// pushed-word layout and the expected-parity helper.
package uart_receiver_pkg;

  localparam int unsigned RX_WORD_W = 11;

  localparam int unsigned UART_LC_PE = 3;
  localparam int unsigned UART_LC_EP = 4;
  localparam int unsigned UART_LC_SP = 5;

  localparam int unsigned RF_BI = 2;
  localparam int unsigned RF_PE = 1;
  localparam int unsigned RF_FE = 0;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StParity   = 3'd3,
    StStop     = 3'd4,
    StWaitHigh = 3'd5
  } rx_state_e;

  // Expected parity bit for {EP,SP}; SP forces the bit to ~EP.
  function automatic logic exp_parity(input logic [7:0] data, input logic ep, input logic sp);
    if (sp) return ~ep;
    return ep ? ^data : ~^data;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Receive-FIFO push bus: one-cycle strobe plus the 11-bit {data, bi, pe, fe} word.
interface uart_receiver_if;
  import uart_receiver_pkg::*;

  logic                 rf_push;
  logic [RX_WORD_W-1:0] rf_data;

  modport master (output rf_push, output rf_data);
  modport slave  (input  rf_push, input  rf_data);
endinterface

// File: rtl/uart_receiver_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous input with a configurable reset value.
module uart_receiver_sync_bit #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b1
) (
  input  logic clk,
  input  logic wb_rst_i,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: 16x-oversampled framing of 5-8 data bits with optional parity,
// flags parity/framing/break and pushes one word per character.
module uart_receiver #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RX_WORD_W   = 11
) (
  input  logic                   clk,
  input  logic                   wb_rst_i,
  input  logic [7:0]             lcr,
  input  logic                   enable,
  input  logic                   srx_pad_i,
  input  logic                   stx_lb_i,
  input  logic                   loopback,
  input  logic                   rx_reset,
  uart_receiver_if.master        rf_if,
  output logic [2:0]             rstate,
  output logic                   rx_busy
);
  import uart_receiver_pkg::*;

  logic                 rx;
  rx_state_e            state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 push_q, push_d;
  logic [RX_WORD_W-1:0] data_q, data_d;
  logic [7:0]           data_al;
  logic                 pe, fe, bi;
  logic                 unused_lcr;

  assign unused_lcr = ^{lcr[7:6], lcr[2]};

  uart_receiver_sync_bit #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b1)
  ) u_sync (
    .clk      (clk),
    .wb_rst_i (wb_rst_i),
    .d        (loopback ? stx_lb_i : srx_pad_i),
    .q        (rx)
  );

  // Bits enter at the MSB, so shift down to right-justify short characters.
  assign data_al = shreg_q >> (2'd3 - lcr[1:0]);
  assign fe      = ~rx;
  assign pe      = lcr[UART_LC_PE] &
                   (par_q != exp_parity(data_al, lcr[UART_LC_EP], lcr[UART_LC_SP]));
  assign bi      = (data_al == 8'h00) & ~(lcr[UART_LC_PE] & par_q) & ~rx;

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      bit_cnt_q <= 3'd0;
      shreg_q   <= 8'h00;
      par_q     <= 1'b0;
      push_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      push_q    <= push_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    push_d    = 1'b0;
    data_d    = data_q;
    if (rx_reset) begin
      state_d   = StIdle;
      cnt_d     = 4'd0;
      bit_cnt_d = 3'd0;
    end else if (enable) begin
      case (state_q)
        StIdle: begin
          if (!rx) begin
            cnt_d   = 4'd7;
            state_d = StStart;
          end
        end
        StStart: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else if (rx) begin
            state_d = StIdle;
          end else begin
            cnt_d     = 4'd15;
            bit_cnt_d = 3'd4 + {1'b0, lcr[1:0]};
            shreg_d   = 8'h00;
            state_d   = StData;
          end
        end
        StData: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            shreg_d = {rx, shreg_q[7:1]};
            cnt_d   = 4'd15;
            if (bit_cnt_q == 3'd0) begin
              state_d = lcr[UART_LC_PE] ? StParity : StStop;
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end
        end
        StParity: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            par_d   = rx;
            cnt_d   = 4'd15;
            state_d = StStop;
          end
        end
        StStop: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            data_d  = '0;
            data_d[RX_WORD_W-1:3] = data_al;
            data_d[RF_BI] = bi;
            data_d[RF_PE] = pe;
            data_d[RF_FE] = fe;
            push_d  = 1'b1;
            state_d = rx ? StIdle : StWaitHigh;
          end
        end
        StWaitHigh: begin
          if (rx) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign rf_if.rf_push = push_q;
  assign rf_if.rf_data = data_q;
  assign rstate        = state_q;
  assign rx_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver: framing, parity, errors, break,
// glitch rejection, rx_reset abort and loopback.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       wb_rst_i;
  logic [7:0] lcr;
  logic       enable;
  logic       srx_pad_i;
  logic       stx_lb_i;
  logic       loopback;
  logic       rx_reset;
  logic [2:0] rstate;
  logic       rx_busy;
  logic       sel_lb;

  int total = 0;
  int bad   = 0;
  int push_cnt = 0;
  logic [10:0] last_data = '0;

  uart_receiver_if rf_if ();

  uart_receiver #(
    .SYNC_STAGES (2),
    .RX_WORD_W   (11)
  ) dut (
    .clk       (clk),
    .wb_rst_i  (wb_rst_i),
    .lcr       (lcr),
    .enable    (enable),
    .srx_pad_i (srx_pad_i),
    .stx_lb_i  (stx_lb_i),
    .loopback  (loopback),
    .rx_reset  (rx_reset),
    .rf_if     (rf_if),
    .rstate    (rstate),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  // 16x tick: one clk high out of every four.
  initial begin
    enable = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rf_if.rf_push) begin
      push_cnt  = push_cnt + 1;
      last_data = rf_if.rf_data;
    end
  end

  task automatic ticks(input int n);
    repeat (n) @(posedge clk iff enable);
    @(negedge clk);
  endtask

  task automatic drive_line(input logic b);
    if (sel_lb) stx_lb_i = b;
    else        srx_pad_i = b;
  endtask

  task automatic send_char(input logic [7:0] data, input int nbits, input logic par_en,
                           input logic par_bit, input logic stop_bit);
    drive_line(1'b0);
    ticks(16);
    for (int i = 0; i < nbits; i++) begin
      drive_line(data[i]);
      ticks(16);
    end
    if (par_en) begin
      drive_line(par_bit);
      ticks(16);
    end
    drive_line(stop_bit);
    ticks(16);
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (rf_if.rf_push !== 1'b0) begin bad++;
      $display("FAIL reset_push got=%b want=0", rf_if.rf_push); end
    total++; if (rf_if.rf_data !== 11'd0) begin bad++;
      $display("FAIL reset_data got=%b want=0", rf_if.rf_data); end
    total++; if (rstate !== 3'd0) begin bad++;
      $display("FAIL reset_rstate got=%0d want=0", rstate); end
    total++; if (rx_busy !== 1'b0) begin bad++;
      $display("FAIL reset_busy got=%b want=0", rx_busy); end
    wb_rst_i = 1'b0;
    ticks(4);
  endtask

  task automatic test_8n1();
    int p0;
    lcr = 8'h03;
    p0 = push_cnt;
    send_char(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    ticks(2);
    total++; if (push_cnt - p0 !== 1) begin bad++;
      $display("FAIL 8n1_pushes got=%0d want=1", push_cnt - p0); end
    total++; if (last_data !== 11'b10100101_000) begin bad++;
      $display("FAIL 8n1_data got=%b want=%b", last_data, 11'b10100101_000); end
    total++; if (rx_busy !== 1'b0) begin bad++;
      $display("FAIL 8n1_busy got=%b want=0", rx_busy); end
    total++; if (rstate !== 3'd0) begin bad++;
      $display("FAIL 8n1_rstate got=%0d want=0", rstate); end
  endtask

  task automatic test_7e1();
    int p0;
    lcr = 8'h1A;
    p0 = push_cnt;
    send_char(8'h35, 7, 1'b1, 1'b0, 1'b1);
    ticks(2);
    total++; if (push_cnt - p0 !== 1) begin bad++;
      $display("FAIL 7e1_good_pushes got=%0d want=1", push_cnt - p0); end
    total++; if (last_data !== 11'b00110101_000) begin bad++;
      $display("FAIL 7e1_good_data got=%b want=%b", last_data, 11'b00110101_000); end
    p0 = push_cnt;
    send_char(8'h35, 7, 1'b1, 1'b1, 1'b1);
    ticks(2);
    total++; if (push_cnt - p0 !== 1) begin bad++;
      $display("FAIL 7e1_bad_pushes got=%0d want=1", push_cnt - p0); end
    total++; if (last_data !== 11'b00110101_010) begin bad++;
      $display("FAIL 7e1_bad_data got=%b want=%b", last_data, 11'b00110101_010); end
  endtask

  task automatic test_framing();
    int p0;
    lcr = 8'h00;
    p0 = push_cnt;
    send_char(8'h1F, 5, 1'b0, 1'b0, 1'b0);
    ticks(2);
    total++; if (push_cnt - p0 !== 1) begin bad++;
      $display("FAIL fe_pushes got=%0d want=1", push_cnt - p0); end
    total++; if (last_data !== 11'b00011111_001) begin bad++;
      $display("FAIL fe_data got=%b want=%b", last_data, 11'b00011111_001); end
    total++; if (rstate !== 3'd5) begin bad++;
      $display("FAIL fe_wait_high got=%0d want=5", rstate); end
    total++; if (rx_busy !== 1'b1) begin bad++;
      $display("FAIL fe_busy got=%b want=1", rx_busy); end
    drive_line(1'b1);
    ticks(4);
    total++; if (rstate !== 3'd0) begin bad++;
      $display("FAIL fe_back_idle got=%0d want=0", rstate); end
  endtask

  task automatic test_break();
    int p0;
    lcr = 8'h03;
    p0 = push_cnt;
    drive_line(1'b0);
    ticks(3 * 10 * 16);
    total++; if (push_cnt - p0 !== 1) begin bad++;
      $display("FAIL brk_pushes got=%0d want=1", push_cnt - p0); end
    total++; if (last_data !== 11'b00000000_101) begin bad++;
      $display("FAIL brk_data got=%b want=%b", last_data, 11'b00000000_101); end
    total++; if (rstate !== 3'd5) begin bad++;
      $display("FAIL brk_wait_high got=%0d want=5", rstate); end
    drive_line(1'b1);
    ticks(20);
    total++; if (push_cnt - p0 !== 1) begin bad++;
      $display("FAIL brk_release_pushes got=%0d want=1", push_cnt - p0); end
    total++; if (rstate !== 3'd0) begin bad++;
      $display("FAIL brk_release_rstate got=%0d want=0", rstate); end
  endtask

  task automatic test_glitch();
    int p0;
    p0 = push_cnt;
    drive_line(1'b0);
    ticks(4);
    drive_line(1'b1);
    ticks(20);
    total++; if (push_cnt - p0 !== 0) begin bad++;
      $display("FAIL glitch_pushes got=%0d want=0", push_cnt - p0); end
    total++; if (rstate !== 3'd0) begin bad++;
      $display("FAIL glitch_rstate got=%0d want=0", rstate); end
  endtask

  task automatic test_rx_reset();
    int p0;
    lcr = 8'h03;
    p0 = push_cnt;
    drive_line(1'b0);
    ticks(16);
    drive_line(1'b1);
    ticks(48);
    total++; if (rstate !== 3'd2) begin bad++;
      $display("FAIL rxr_in_data got=%0d want=2", rstate); end
    rx_reset = 1'b1;
    @(negedge clk);
    rx_reset = 1'b0;
    total++; if (rstate !== 3'd0) begin bad++;
      $display("FAIL rxr_abort got=%0d want=0", rstate); end
    ticks(200);
    send_char(8'h5A, 8, 1'b0, 1'b0, 1'b1);
    ticks(2);
    total++; if (push_cnt - p0 !== 1) begin bad++;
      $display("FAIL rxr_pushes got=%0d want=1", push_cnt - p0); end
    total++; if (last_data !== 11'b01011010_000) begin bad++;
      $display("FAIL rxr_data got=%b want=%b", last_data, 11'b01011010_000); end
  endtask

  task automatic test_loopback();
    int p0;
    lcr = 8'h03;
    p0 = push_cnt;
    stx_lb_i = 1'b1;
    loopback = 1'b1;
    srx_pad_i = 1'b0;
    sel_lb = 1'b1;
    ticks(4);
    send_char(8'hC3, 8, 1'b0, 1'b0, 1'b1);
    ticks(2);
    total++; if (push_cnt - p0 !== 1) begin bad++;
      $display("FAIL lb_pushes got=%0d want=1", push_cnt - p0); end
    total++; if (last_data !== 11'b11000011_000) begin bad++;
      $display("FAIL lb_data got=%b want=%b", last_data, 11'b11000011_000); end
    srx_pad_i = 1'b1;
    sel_lb = 1'b0;
    ticks(2);
    loopback = 1'b0;
  endtask

  initial begin
    wb_rst_i  = 1'b1;
    lcr       = 8'h03;
    srx_pad_i = 1'b1;
    stx_lb_i  = 1'b1;
    loopback  = 1'b0;
    rx_reset  = 1'b0;
    sel_lb    = 1'b0;
    test_reset();
    test_8n1();
    test_7e1();
    test_framing();
    test_break();
    test_glitch();
    test_rx_reset();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
